// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one unified memory port between an instruction-fetch requester and a
//   load/store requester. One transaction is outstanding at a time. Data
//   requests win contention, except that after MAX_D_STREAK consecutive
//   contended data grants the waiting fetch is served. A wait counter aborts a
//   transfer that sees no mem_done within TIMEOUT serve cycles. An aborted
//   transfer still completes toward its owner, but with xfer_err set.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   if_req/if_addr              fetch request, word address held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch accept pulse, completion pulse, fetched word
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request, fields held until d_gnt
//   d_gnt/d_rvalid/d_rdata      data accept pulse, completion pulse, load data
//   xfer_err                    marks an rvalid pulse whose transfer timed out
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  command to memory (zero when idle)
//   mem_done/mem_rdata          memory completion strobe and read data
//   busy                        a transaction is being served
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                xfer_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int STK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  // Last wait-count value before the timeout fires: the counter starts at 0 in
  // the first serve cycle, so TIMEOUT cycles without mem_done end here.
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [STK_W-1:0]  STREAK_MAX = STK_W'(MAX_D_STREAK);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_D  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [STK_W-1:0]  streak_reg;
  logic [CNT_W-1:0]  wait_reg;
  logic              lat_we_reg;
  logic [BE_W-1:0]   lat_be_reg;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic [DATA_W-1:0] lat_wdata_reg;
  logic              if_rvalid_reg;
  logic              d_rvalid_reg;
  logic              err_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;

  logic grant_if;
  logic grant_d;
  logic serving;
  logic wait_expired;

  assign serving      = (state_reg != IDLE);
  assign wait_expired = (wait_reg == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Grants are combinational, so they are also gated while reset is
        // held: nothing may be accepted that the reset would then discard.
        if (!reset) begin
          if (d_req && (!if_req || (streak_reg != STREAK_MAX))) begin
            grant_d    = 1'b1;
            state_next = SERVE_D;
          end else if (if_req) begin
            grant_if   = 1'b1;
            state_next = SERVE_IF;
          end
        end
      end
      SERVE_IF, SERVE_D: begin
        // Completion and timeout both end the transfer. Which of the two it
        // was only matters for the status registers below.
        if (mem_done || wait_expired) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, wait counter, streak counter and completion registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_reg    <= '0;
      wait_reg      <= '0;
      lat_we_reg    <= 1'b0;
      lat_be_reg    <= '0;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      err_reg       <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      // Completion strobes are single-cycle pulses.
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      err_reg       <= 1'b0;

      if (grant_if) begin
        // Fetches are always full-word reads from a word-aligned address.
        lat_we_reg    <= 1'b0;
        lat_be_reg    <= '1;
        lat_addr_reg  <= if_addr & ALIGN_MASK;
        lat_wdata_reg <= '0;
        wait_reg      <= '0;
        streak_reg    <= '0;
      end else if (grant_d) begin
        lat_we_reg    <= d_we;
        lat_be_reg    <= d_be;
        lat_addr_reg  <= d_addr;
        lat_wdata_reg <= d_wdata;
        wait_reg      <= '0;
        // Only grants that actually made a fetch wait count toward the streak.
        if (if_req && (streak_reg != STREAK_MAX)) begin
          streak_reg <= streak_reg + STK_W'(1);
        end
      end

      if (serving) begin
        if (mem_done) begin
          // A real completion beats a timeout landing in the same cycle.
          if (state_reg == SERVE_IF) begin
            if_rvalid_reg <= 1'b1;
            if_rdata_reg  <= mem_rdata;
          end else begin
            d_rvalid_reg <= 1'b1;
            if (!lat_we_reg) begin
              d_rdata_reg <= mem_rdata;
            end
          end
        end else if (wait_expired) begin
          err_reg <= 1'b1;
          if (state_reg == SERVE_IF) begin
            if_rvalid_reg <= 1'b1;
          end else begin
            d_rvalid_reg <= 1'b1;
          end
        end else begin
          wait_reg <= wait_reg + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Memory command fields read as zero whenever nothing is being
  // served, so the memory never sees a stale command outside a transfer.
  // ---------------------------------------------------------------------------
  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign xfer_err  = err_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign busy      = serving;
  assign mem_req   = serving;
  assign mem_we    = serving & lat_we_reg;
  assign mem_addr  = serving ? lat_addr_reg : '0;

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign mem_be[gi]           = serving & lat_be_reg[gi];
      assign mem_wdata[gi*8 +: 8] = serving ? lat_wdata_reg[gi*8 +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (TIMEOUT = 8, MAX_D_STREAK = 4).
// Directed table of per-cycle vectors (aligned fetch, load, byte-enabled store,
// stray mem_done in idle), hand sequences for contention order, timeout,
// done-at-timeout and reset mid-transfer, then random traffic compared against
// a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          xfer_err;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .xfer_err(xfer_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired, got no event, expected one (t=%0t)", name, $time);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2
  // units later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_done  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed per-cycle vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          e_if_gnt;
    logic          e_d_gnt;
    logic          e_mreq;
    logic          e_mwe;
    logic [BW-1:0] e_mbe;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwd;
    logic          e_ifrv;
    logic          e_drv;
    logic          e_err;
    logic [DW-1:0] e_ifrd;
    logic [DW-1:0] e_drd;
    logic          e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
    input logic [BW-1:0] dbe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
    input logic md, input logic [DW-1:0] mrd,
    input logic eig, input logic edg, input logic emr, input logic emw,
    input logic [BW-1:0] emb, input logic [AW-1:0] ema, input logic [DW-1:0] emd,
    input logic eirv, input logic edrv, input logic eerr,
    input logic [DW-1:0] eird, input logic [DW-1:0] edrd, input logic eb);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dwe;  v.d_be = dbe;
    v.d_addr = da;  v.d_wdata = dwd; v.mem_done = md; v.mem_rdata = mrd;
    v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_mreq = emr; v.e_mwe = emw;
    v.e_mbe = emb; v.e_maddr = ema; v.e_mwd = emd;
    v.e_ifrv = eirv; v.e_drv = edrv; v.e_err = eerr;
    v.e_ifrd = eird; v.e_drd = edrd; v.e_busy = eb;
    return v;
  endfunction

  vec_t vecs[15];

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, ".if_gnt"},    if_gnt,    v.e_if_gnt);
    chk({tag, ".d_gnt"},     d_gnt,     v.e_d_gnt);
    chk({tag, ".mem_req"},   mem_req,   v.e_mreq);
    chk({tag, ".mem_we"},    mem_we,    v.e_mwe);
    chk({tag, ".mem_be"},    mem_be,    v.e_mbe);
    chk({tag, ".mem_addr"},  mem_addr,  v.e_maddr);
    chk({tag, ".mem_wdata"}, mem_wdata, v.e_mwd);
    chk({tag, ".if_rvalid"}, if_rvalid, v.e_ifrv);
    chk({tag, ".d_rvalid"},  d_rvalid,  v.e_drv);
    chk({tag, ".xfer_err"},  xfer_err,  v.e_err);
    chk({tag, ".if_rdata"},  if_rdata,  v.e_ifrd);
    chk({tag, ".d_rdata"},   d_rdata,   v.e_drd);
    chk({tag, ".busy"},      busy,      v.e_busy);
  endtask

  // Both requesters held high; memory answers in the first mem_req cycle.
  // pat bit i = 1 means grant i must go to data, 0 means fetch.
  task automatic contention(input int n, input logic [15:0] pat, input string name);
    int got    = 0;
    int cycles = 0;
    while (got < n && cycles < 40 * n) begin
      tick();
      if_req    = 1'b1; if_addr = 32'h0000_1004;
      d_req     = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_3000; d_wdata = '0;
      mem_done  = mem_req;
      mem_rdata = $urandom;
      settle();
      cycles++;
      chk($sformatf("%s.onehot_c%0d", name, cycles), {1'b0, if_gnt & d_gnt}, 2'b00);
      if (if_gnt || d_gnt) begin
        chk($sformatf("%s.grant%0d_is_data", name, got), d_gnt, pat[got]);
        $display("%s: grant %0d to %s", name, got, d_gnt ? "D" : "F");
        got++;
      end
    end
    if (got < n) bound_fail({name, ".grants"});
  endtask

  // Single load that completes after one memory cycle; checks the returned data.
  task automatic load_ok(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string name);
    tick(); d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = addr; d_wdata = '0; settle();
    chk({name, ".d_gnt"}, d_gnt, 1'b1);
    tick(); d_req = 1'b0; mem_done = 1'b1; mem_rdata = data; settle();
    tick(); mem_done = 1'b0; settle();
    chk({name, ".d_rvalid"}, d_rvalid, 1'b1);
    chk({name, ".d_rdata"},  d_rdata,  data);
    $display("%s: load 0x%0h -> 0x%0h", name, addr, d_rdata);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state (transaction level)
  // ---------------------------------------------------------------------------
  int            m_owner;     // 0 none, 1 fetch, 2 data
  int            m_waited;
  int            m_streak;
  logic          m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_if_rv, m_d_rv, m_err;
  logic [DW-1:0] m_if_rdata, m_d_rdata;

  initial begin
    int cnt;
    int pct;
    int n_xfer;
    logic f_act, d_act;
    logic e_f, e_d;
    vec_t ev;
    logic [AW-1:0] ia;

    reset = 1'b1;
    idle_inputs();
    if_addr = '0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

    // ---- reset state, with both requests raised while reset is held ----
    if_req = 1'b1; d_req = 1'b1;
    #3;
    chk("rst.if_gnt",   if_gnt,   1'b0);
    chk("rst.d_gnt",    d_gnt,    1'b0);
    chk("rst.mem_req",  mem_req,  1'b0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_be",   mem_be,   4'h0);
    chk("rst.busy",     busy,     1'b0);
    chk("rst.xfer_err", xfer_err, 1'b0);
    chk("rst.if_rdata", if_rdata, 32'h0);
    chk("rst.d_rdata",  d_rdata,  32'h0);
    do_reset();

    // ---- table: aligned fetch (V1), load, byte-enabled store (V3), stray done ----
    vecs[0]  = mk(1,'h103,0,0,0,0,0, 0,0,            1,0,0,0,0,0,0, 0,0,0, 0,0,0);
    vecs[1]  = mk(0,'h103,0,0,0,0,0, 0,0,            0,0,1,0,'hF,'h100,0, 0,0,0, 0,0,1);
    vecs[2]  = mk(0,'h103,0,0,0,0,0, 0,0,            0,0,1,0,'hF,'h100,0, 0,0,0, 0,0,1);
    vecs[3]  = mk(0,'h103,0,0,0,0,0, 1,'h11223344,   0,0,1,0,'hF,'h100,0, 0,0,0, 0,0,1);
    vecs[4]  = mk(0,'h103,0,0,0,0,0, 0,0,            0,0,0,0,0,0,0, 1,0,0, 'h11223344,0,0);
    vecs[5]  = mk(0,'h103,0,0,0,0,0, 0,0,            0,0,0,0,0,0,0, 0,0,0, 'h11223344,0,0);
    vecs[6]  = mk(0,0,1,0,'hF,'h40,0, 0,0,           0,1,0,0,0,0,0, 0,0,0, 'h11223344,0,0);
    vecs[7]  = mk(0,0,0,0,'hF,'h40,0, 1,'h55667788,  0,0,1,0,'hF,'h40,0, 0,0,0, 'h11223344,0,1);
    vecs[8]  = mk(0,0,0,0,0,0,0, 0,0,                0,0,0,0,0,0,0, 0,1,0, 'h11223344,'h55667788,0);
    vecs[9]  = mk(0,0,1,1,'h3,'h2000,'hAABBCCDD, 0,0, 0,1,0,0,0,0,0, 0,0,0, 'h11223344,'h55667788,0);
    vecs[10] = mk(0,0,0,1,'h3,'h2000,'hAABBCCDD, 0,0, 0,0,1,1,'h3,'h2000,'hAABBCCDD, 0,0,0, 'h11223344,'h55667788,1);
    vecs[11] = mk(0,0,0,1,'h3,'h2000,'hAABBCCDD, 1,'hDEADBEEF,
                                                     0,0,1,1,'h3,'h2000,'hAABBCCDD, 0,0,0, 'h11223344,'h55667788,1);
    vecs[12] = mk(0,0,0,0,0,0,0, 0,0,                0,0,0,0,0,0,0, 0,1,0, 'h11223344,'h55667788,0);
    vecs[13] = mk(0,0,0,0,0,0,0, 1,'h99999999,       0,0,0,0,0,0,0, 0,0,0, 'h11223344,'h55667788,0);
    vecs[14] = mk(0,0,0,0,0,0,0, 0,0,                0,0,0,0,0,0,0, 0,0,0, 'h11223344,'h55667788,0);

    for (int i = 0; i < 15; i++) begin
      tick();
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_be = vecs[i].d_be;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      mem_done = vecs[i].mem_done; mem_rdata = vecs[i].mem_rdata;
      settle();
      check_outputs($sformatf("vec%0d", i), vecs[i]);
      if (if_rvalid || d_rvalid)
        $display("vec%0d: completion if_rvalid=%0d d_rvalid=%0d err=%0d", i, if_rvalid, d_rvalid, xfer_err);
    end

    // ---- contention order (V2) ----
    do_reset();
    contention(10, 16'h01EF, "v2");

    // ---- timeout (V4) ----
    do_reset();
    load_ok(32'h500, 32'h1234_5678, "v4pre");
    tick(); d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h504; settle();
    chk("v4.d_gnt", d_gnt, 1'b1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick(); d_req = 1'b0; mem_done = 1'b0; mem_rdata = 32'hFFFF_FFFF; settle();
      if (mem_req) cnt++;
      if (d_rvalid) break;
    end
    if (!d_rvalid) bound_fail("v4.d_rvalid");
    chk("v4.mem_req_cycles", cnt, 8);
    chk("v4.mem_req_at_rvalid", mem_req, 1'b0);
    chk("v4.xfer_err", xfer_err, 1'b1);
    chk("v4.if_rvalid", if_rvalid, 1'b0);
    chk("v4.d_rdata_kept", d_rdata, 32'h1234_5678);
    $display("v4: timed-out load completed err=%0d", xfer_err);
    tick(); settle();
    chk("v4.busy_after", busy, 1'b0);
    chk("v4.d_rvalid_after", d_rvalid, 1'b0);
    chk("v4.err_after", xfer_err, 1'b0);

    // ---- mem_done in the timeout cycle (V6) ----
    tick(); d_req = 1'b1; d_addr = 32'h508; settle();
    chk("v6.d_gnt", d_gnt, 1'b1);
    for (int c = 1; c <= TO; c++) begin
      tick(); d_req = 1'b0; mem_done = (c == TO); mem_rdata = 32'hCAFE_F00D; settle();
      chk($sformatf("v6.mem_req_c%0d", c), mem_req, 1'b1);
    end
    tick(); mem_done = 1'b0; settle();
    chk("v6.d_rvalid", d_rvalid, 1'b1);
    chk("v6.xfer_err", xfer_err, 1'b0);
    chk("v6.d_rdata", d_rdata, 32'hCAFE_F00D);
    $display("v6: load completed at timeout boundary err=%0d", xfer_err);

    // ---- reset mid-SERVE_D, stray mem_done afterwards (V5) ----
    do_reset();
    contention(3, 16'h0007, "v5pre");
    tick(); mem_done = 1'b0; settle();
    chk("v5.in_serve_d", {busy, mem_req}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("v5.mem_req_now", mem_req, 1'b0);
    chk("v5.busy_now", busy, 1'b0);
    chk("v5.gnt_in_reset", {if_gnt, d_gnt}, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      mem_done = (c < 2); mem_rdata = 32'h7777_7777;
      settle();
      chk($sformatf("v5.no_rvalid_c%0d", c), {if_rvalid, d_rvalid, xfer_err}, 3'b000);
      chk($sformatf("v5.idle_c%0d", c), {busy, mem_req}, 2'b00);
      tick();
    end
    mem_done = 1'b0;
    contention(10, 16'h01EF, "v5post");

    // ---- randomized traffic against the reference model ----
    do_reset();
    m_owner = 0; m_waited = 0; m_streak = 0;
    m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
    m_if_rv = 1'b0; m_d_rv = 1'b0; m_err = 1'b0;
    m_if_rdata = '0; m_d_rdata = '0;
    f_act = 1'b0; d_act = 1'b0; n_xfer = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!f_act && $urandom_range(0, 2) == 0) begin
        f_act = 1'b1; if_addr = $urandom;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if_req = f_act; d_req = d_act;
      pct = (cyc < 1500) ? 35 : 6;
      mem_done  = ($urandom_range(0, 99) < pct);
      mem_rdata = $urandom;

      // Arbitration decision from the rules.
      e_f = 1'b0; e_d = 1'b0;
      if (m_owner == 0) begin
        if (if_req && d_req) begin
          if (m_streak == MAXS) e_f = 1'b1; else e_d = 1'b1;
        end else if (if_req) e_f = 1'b1;
        else if (d_req) e_d = 1'b1;
      end

      ev = mk(0,0,0,0,0,0,0,0,0,
              e_f, e_d, (m_owner != 0), (m_owner != 0) ? m_we : 1'b0,
              (m_owner != 0) ? m_be : 4'h0, (m_owner != 0) ? m_addr : 32'h0,
              (m_owner != 0) ? m_wdata : 32'h0,
              m_if_rv, m_d_rv, m_err, m_if_rdata, m_d_rdata, (m_owner != 0));
      settle();
      check_outputs($sformatf("rand%0d", cyc), ev);
      if (if_rvalid || d_rvalid) begin
        n_xfer++;
        $display("rand xfer %0d: owner=%s err=%0d", n_xfer, if_rvalid ? "F" : "D", xfer_err);
      end

      // Advance the model across the clock edge.
      m_if_rv = 1'b0; m_d_rv = 1'b0; m_err = 1'b0;
      if (m_owner != 0) begin
        if (mem_done) begin
          if (m_owner == 1) begin
            m_if_rv = 1'b1; m_if_rdata = mem_rdata;
          end else begin
            m_d_rv = 1'b1;
            if (!m_we) m_d_rdata = mem_rdata;
          end
          m_owner = 0;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_err = 1'b1;
            if (m_owner == 1) m_if_rv = 1'b1; else m_d_rv = 1'b1;
            m_owner = 0;
          end
        end
      end else if (e_f) begin
        ia = if_addr;
        m_owner = 1; m_we = 1'b0; m_be = 4'hF; m_addr = {ia[AW-1:2], 2'b00};
        m_wdata = '0; m_waited = 0; m_streak = 0;
        f_act = 1'b0;
      end else if (e_d) begin
        m_owner = 2; m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
        m_waited = 0;
        if (if_req && m_streak < MAXS) m_streak++;
        d_act = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
